// File: rtl/neo_sys_pkg.sv
// Shared System-block definitions: the power-on state encoding and the default
// timing constants used by the system top and its clock/reset helpers.
package neo_sys_pkg;

  typedef enum logic {
    POR_HOLD = 1'b0,
    RUN      = 1'b1
  } sys_state_e;

  localparam int unsigned POR_CYCLES_DEF = 1024;
  localparam int unsigned WD_PULSE_DEF   = 8;
  localparam int unsigned FRAME_DIV_DEF  = 1;

  localparam int unsigned PUL_CNT_W = 8;
  localparam int unsigned DIV_CNT_W = 4;

endpackage

// File: rtl/sync_rise.sv
// Two-flop synchroniser for an asynchronous level, followed by an edge register
// producing a registered single-cycle strobe on each synchronised rising edge.
module sync_rise (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync3;
  logic r_rise;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_rise  <= r_sync2 & ~r_sync3;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/wdclk_gen.sv
// Watchdog frame tick (WDCLK) from LSPC VBLANK, plus the power-on nRST hold.
// All outputs are registered in the CLK_24M domain.
module wdclk_gen
  import neo_sys_pkg::*;
#(
  parameter int unsigned POR_CYCLES = POR_CYCLES_DEF,
  parameter int unsigned WD_PULSE   = WD_PULSE_DEF,
  parameter int unsigned FRAME_DIV  = FRAME_DIV_DEF
) (
  input  logic CLK_24M,
  input  logic RST,
  input  logic VBLANK,
  output logic nRST,
  output logic WDCLK,
  output logic POR_DONE
);

  localparam int unsigned POR_W = $clog2(POR_CYCLES);

  localparam logic [POR_W-1:0]     POR_LAST = POR_W'(POR_CYCLES - 1);
  localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(FRAME_DIV - 1);
  localparam logic [PUL_CNT_W-1:0] PUL_LOAD = PUL_CNT_W'(WD_PULSE - 1);

  sys_state_e           r_state;
  sys_state_e           w_state_next;
  logic [POR_W-1:0]     r_por_cnt;
  logic [POR_W-1:0]     w_por_cnt_next;
  logic                 r_nrst;
  logic                 r_por_done;

  logic                 w_rise;
  logic                 w_run;
  logic                 w_tick;
  logic [DIV_CNT_W-1:0] r_div_cnt;

  logic                 r_wdclk;
  logic [PUL_CNT_W-1:0] r_pul_cnt;
  logic                 r_pending;

  sync_rise u_vblank_sync (
    .i_clk   (CLK_24M),
    .i_rst   (RST),
    .i_async (VBLANK),
    .o_rise  (w_rise)
  );

  always_ff @(posedge CLK_24M or posedge RST) begin
    if (RST) begin
      r_state    <= POR_HOLD;
      r_por_cnt  <= '0;
      r_nrst     <= 1'b0;
      r_por_done <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_por_cnt  <= w_por_cnt_next;
      r_nrst     <= (w_state_next == RUN);
      r_por_done <= (w_state_next == RUN);
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_por_cnt_next = r_por_cnt;
    case (r_state)
      POR_HOLD: begin
        if (r_por_cnt == POR_LAST) begin
          w_state_next   = RUN;
          w_por_cnt_next = '0;
        end else begin
          w_por_cnt_next = r_por_cnt + 1'b1;
        end
      end
      RUN: begin
        w_state_next = RUN;
      end
      default: begin
        w_state_next   = POR_HOLD;
        w_por_cnt_next = '0;
      end
    endcase
  end

  // Edges seen during the POR hold are neither counted nor turned into ticks.
  assign w_run  = (r_state == RUN);
  assign w_tick = w_run & w_rise & (r_div_cnt == DIV_LAST);

  always_ff @(posedge CLK_24M or posedge RST) begin
    if (RST) begin
      r_div_cnt <= '0;
    end else if (w_run && w_rise) begin
      if (r_div_cnt == DIV_LAST) begin
        r_div_cnt <= '0;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end
    end
  end

  // A tick during a pulse is parked in r_pending; the idle branch then restarts
  // one cycle after the pulse drops, guaranteeing a distinct WDCLK posedge.
  always_ff @(posedge CLK_24M or posedge RST) begin
    if (RST) begin
      r_wdclk   <= 1'b0;
      r_pul_cnt <= '0;
      r_pending <= 1'b0;
    end else if (r_wdclk) begin
      if (w_tick) begin
        r_pending <= 1'b1;
      end
      if (r_pul_cnt == '0) begin
        r_wdclk <= 1'b0;
      end else begin
        r_pul_cnt <= r_pul_cnt - 1'b1;
      end
    end else if (r_pending || w_tick) begin
      r_wdclk   <= 1'b1;
      r_pul_cnt <= PUL_LOAD;
      r_pending <= 1'b0;
    end
  end

  assign nRST     = r_nrst;
  assign WDCLK    = r_wdclk;
  assign POR_DONE = r_por_done;

endmodule

// File: tb/tb_wdclk_gen.sv
// Directed bench for wdclk_gen: three instances with different parameter sets,
// expected WDCLK pulses queued at stimulus time and checked on pulse completion.
module tb_wdclk_gen;

  typedef struct {
    int unsigned rise;
    int unsigned width;
  } exp_t;

  logic clk;
  logic rst_a, rst_b, rst_c;
  logic vb_a, vb_b, vb_c;
  logic nrst_a, nrst_b, nrst_c;
  logic wd_a, wd_b, wd_c;
  logic pd_a, pd_b, pd_c;

  int unsigned cyc;
  int unsigned n_assert;
  int unsigned n_fail;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  logic        wd_v[3];
  logic        rs_v[3];
  logic        in_pulse[3];
  int unsigned st[3];
  int unsigned wid[3];
  int unsigned npulse[3];

  wdclk_gen #(.POR_CYCLES(16), .WD_PULSE(8), .FRAME_DIV(1)) dut_a (
    .CLK_24M(clk), .RST(rst_a), .VBLANK(vb_a),
    .nRST(nrst_a), .WDCLK(wd_a), .POR_DONE(pd_a)
  );

  wdclk_gen #(.POR_CYCLES(16), .WD_PULSE(8), .FRAME_DIV(3)) dut_b (
    .CLK_24M(clk), .RST(rst_b), .VBLANK(vb_b),
    .nRST(nrst_b), .WDCLK(wd_b), .POR_DONE(pd_b)
  );

  wdclk_gen #(.POR_CYCLES(16), .WD_PULSE(20), .FRAME_DIV(1)) dut_c (
    .CLK_24M(clk), .RST(rst_c), .VBLANK(vb_c),
    .nRST(nrst_c), .WDCLK(wd_c), .POR_DONE(pd_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  assign wd_v[0] = wd_a;
  assign wd_v[1] = wd_b;
  assign wd_v[2] = wd_c;
  assign rs_v[0] = rst_a;
  assign rs_v[1] = rst_b;
  assign rs_v[2] = rst_c;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_done(input int d, input int unsigned s, input int unsigned w);
    exp_t e;
    bit   have;
    have = 1'b0;
    case (d)
      0: if (q_a.size() > 0) begin e = q_a.pop_front(); have = 1'b1; end
      1: if (q_b.size() > 0) begin e = q_b.pop_front(); have = 1'b1; end
      default: if (q_c.size() > 0) begin e = q_c.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      check($sformatf("unexpected_pulse_dut%0d_rise_cycle", d), s, 0);
    end else begin
      check($sformatf("pulse_rise_cycle_dut%0d", d), s, e.rise);
      check($sformatf("pulse_width_dut%0d", d), w, e.width);
    end
  endtask

  // Pulse monitor: pulses cut short by reset are discarded, not scored.
  initial begin
    for (int d = 0; d < 3; d++) begin
      in_pulse[d] = 1'b0;
      st[d]       = 0;
      wid[d]      = 0;
      npulse[d]   = 0;
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rs_v[d]) begin
        in_pulse[d] = 1'b0;
      end else if (wd_v[d] === 1'b1) begin
        if (!in_pulse[d]) begin
          in_pulse[d] = 1'b1;
          st[d]       = cyc;
          wid[d]      = 1;
        end else begin
          wid[d]++;
        end
      end else if (in_pulse[d]) begin
        in_pulse[d] = 1'b0;
        npulse[d]++;
        pulse_done(d, st[d], wid[d]);
      end
    end
  end

  initial begin
    int unsigned c;
    n_assert = 0;
    n_fail   = 0;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    vb_a  = 1'b0; vb_b  = 1'b0; vb_c  = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_nrst_a", nrst_a, 0);
    check("rst_wdclk_a", wd_a, 0);
    check("rst_pordone_a", pd_a, 0);
    check("rst_nrst_b", nrst_b, 0);
    check("rst_wdclk_b", wd_b, 0);
    check("rst_pordone_b", pd_b, 0);
    check("rst_nrst_c", nrst_c, 0);
    check("rst_wdclk_c", wd_c, 0);
    check("rst_pordone_c", pd_c, 0);

    // POR hold: 16 edges, VBLANK toggling on dut_a must not tick
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      vb_a = (i < 8) ? i[1] : 1'b0;
    end
    check("por15_nrst_a", nrst_a, 0);
    check("por15_pordone_a", pd_a, 0);
    check("por15_nrst_b", nrst_b, 0);
    check("por15_nrst_c", nrst_c, 0);
    check("por15_wdclk_a", wd_a, 0);
    @(negedge clk);
    check("por16_nrst_a", nrst_a, 1);
    check("por16_pordone_a", pd_a, 1);
    check("por16_nrst_b", nrst_b, 1);
    check("por16_pordone_b", pd_b, 1);
    check("por16_nrst_c", nrst_c, 1);
    check("por16_pordone_c", pd_c, 1);

    // VBLANK high across reset release (dut_c) gives no tick
    repeat (12) @(negedge clk);

    // Basic: 4 frames on dut_a -> 4 pulses of 8
    for (int f = 0; f < 4; f++) begin
      c = cyc;
      vb_a = 1'b1;
      q_a.push_back('{rise: c + 4, width: 8});
      repeat (4) @(negedge clk);
      vb_a = 1'b0;
      repeat (16) @(negedge clk);
    end

    // Divide by 3 on dut_b: 9 rises -> pulses on rises 3, 6, 9
    for (int r = 1; r <= 9; r++) begin
      c = cyc;
      vb_b = 1'b1;
      if (r % 3 == 0) q_b.push_back('{rise: c + 4, width: 8});
      repeat (3) @(negedge clk);
      vb_b = 1'b0;
      repeat (5) @(negedge clk);
    end
    repeat (12) @(negedge clk);

    // Overlap on dut_c: second rise pends, third is dropped
    vb_c = 1'b0;
    repeat (5) @(negedge clk);
    c = cyc;
    vb_c = 1'b1;
    q_c.push_back('{rise: c + 4, width: 20});
    q_c.push_back('{rise: c + 25, width: 20});
    repeat (2) @(negedge clk); vb_c = 1'b0;
    repeat (3) @(negedge clk); vb_c = 1'b1;
    repeat (2) @(negedge clk); vb_c = 1'b0;
    repeat (3) @(negedge clk); vb_c = 1'b1;
    repeat (2) @(negedge clk); vb_c = 1'b0;
    repeat (60) @(negedge clk);

    // Reset on cycle 4 of a pulse with a tick already pending
    c = cyc;
    vb_c = 1'b1;
    @(negedge clk); vb_c = 1'b0;
    @(negedge clk); vb_c = 1'b1;
    @(negedge clk); vb_c = 1'b0;
    repeat (4) @(negedge clk);
    check("midpulse_wdclk_high_c", wd_c, 1);
    rst_c = 1'b1;
    #1;
    check("midrst_wdclk_c", wd_c, 0);
    check("midrst_nrst_c", nrst_c, 0);
    check("midrst_pordone_c", pd_c, 0);
    repeat (3) @(negedge clk);
    rst_c = 1'b0;
    repeat (15) @(negedge clk);
    check("repor15_nrst_c", nrst_c, 0);
    check("repor15_pordone_c", pd_c, 0);
    check("repor15_wdclk_c", wd_c, 0);
    @(negedge clk);
    check("repor16_nrst_c", nrst_c, 1);
    check("repor16_pordone_c", pd_c, 1);
    repeat (30) @(negedge clk);

    // Fresh frame after re-POR: exactly one normal pulse
    c = cyc;
    vb_c = 1'b1;
    q_c.push_back('{rise: c + 4, width: 20});
    repeat (3) @(negedge clk);
    vb_c = 1'b0;
    repeat (40) @(negedge clk);

    check("pulse_count_a", npulse[0], 4);
    check("pulse_count_b", npulse[1], 3);
    check("pulse_count_c", npulse[2], 3);
    check("missing_pulses_a", q_a.size(), 0);
    check("missing_pulses_b", q_b.size(), 0);
    check("missing_pulses_c", q_c.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
